// File: rtl/serial_adder_pkg.sv
// Shared types and sizing helpers for the bit-serial adder.
package serial_adder_pkg;

  localparam int DEF_WIDTH = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Bit counter width; never below 1 so the counter always exists.
  function automatic int cnt_w(input int w);
    return (w < 2) ? 1 : $clog2(w);
  endfunction

endpackage

// File: rtl/serial_adder_full_adder.sv
// Single combinational 1-bit full-adder cell for the serial datapath.
module full_adder (
  input  logic i_a,
  input  logic i_b,
  input  logic i_cin,
  output logic o_sum,
  output logic o_cout
);

  assign o_sum  = i_a ^ i_b ^ i_cin;
  assign o_cout = (i_a & i_b) | (i_a & i_cin) | (i_b & i_cin);

endmodule

// File: rtl/serial_adder.sv
// Bit-serial adder: one full-adder cell plus carry flop, LSB first over WIDTH cycles.
// Optional signed-overflow output enabled by defining SERIAL_ADDER_OVF_EN.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef SERIAL_ADDER_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int CW = cnt_w(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_e           r_state;
  logic [WIDTH-1:0] r_a, r_b, r_sum;
  logic             r_carry, r_cout, r_busy, r_done;
  logic [CW-1:0]    r_cnt;
  logic             w_s, w_c;
`ifdef SERIAL_ADDER_OVF_EN
  logic             r_ovf;
`endif

  full_adder u_fa (
    .i_a   (r_a[0]),
    .i_b   (r_b[0]),
    .i_cin (r_carry),
    .o_sum (w_s),
    .o_cout(w_c)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_sum   <= '0;
      r_carry <= 1'b0;
      r_cout  <= 1'b0;
      r_cnt   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
      r_ovf   <= 1'b0;
`endif
    end else begin
      case (r_state)
        ST_IDLE, ST_DONE: begin
          r_done <= 1'b0;
          // Sum/cout stay untouched here so the previous result remains visible.
          if (start) begin
            r_a     <= a;
            r_b     <= b;
            r_carry <= cin;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
            r_state <= ST_RUN;
          end else begin
            r_state <= ST_IDLE;
          end
        end
        ST_RUN: begin
          r_a     <= r_a >> 1;
          r_b     <= r_b >> 1;
          r_carry <= w_c;
          r_sum   <= {w_s, r_sum[WIDTH-1:1]};
          r_cnt   <= r_cnt + 1'b1;
          if (r_cnt == LAST) begin
            r_cout  <= w_c;
`ifdef SERIAL_ADDER_OVF_EN
            // r_carry is the carry into the MSB on this final edge.
            r_ovf   <= r_carry ^ w_c;
`endif
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= ST_DONE;
          end
        end
        default: begin
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign busy = r_busy;
  assign done = r_done;
  assign sum  = r_sum;
  assign cout = r_cout;
`ifdef SERIAL_ADDER_OVF_EN
  assign ovf  = r_ovf;
`endif

endmodule

// File: tb/tb_serial_adder.sv
// Directed + random bench for serial_adder with a queue scoreboard of expected results.
module tb_serial_adder;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [W-1:0] a, b;
  logic         cin;
  logic         busy, done, cout;
  logic [W-1:0] sum;
`ifdef SERIAL_ADDER_OVF_EN
  logic         ovf;
`endif

  serial_adder #(.WIDTH(W)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .start(start),
    .a    (a),
    .b    (b),
    .cin  (cin),
    .busy (busy),
    .done (done),
    .sum  (sum),
    .cout (cout)
`ifdef SERIAL_ADDER_OVF_EN
    ,
    .ovf  (ovf)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] s;
    logic         c;
    logic         v;
  } exp_t;

  exp_t q[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   n_start = 0;
  int   n_done = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y, input logic ci);
    exp_t        e;
    logic [W:0]  full;
    full = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, ci};
    e.s  = full[W-1:0];
    e.c  = full[W];
    e.v  = (x[W-1] == y[W-1]) && (full[W-1] != x[W-1]);
    return e;
  endfunction

  // Scoreboard: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && done === 1'b1) begin
      exp_t e;
      n_done++;
      if (q.size() == 0) begin
        chk("unexpected_done", 32'(done), 32'd0);
      end else begin
        e = q.pop_front();
        chk("sum", 32'(sum), 32'(e.s));
        chk("cout", 32'(cout), 32'(e.c));
`ifdef SERIAL_ADDER_OVF_EN
        chk("ovf", 32'(ovf), 32'(e.v));
`endif
      end
    end
  end

  // Drive at a negedge, let one posedge sample it, drop start at the next negedge.
  task automatic start_op(input logic [W-1:0] x, input logic [W-1:0] y, input logic ci,
                          input bit expect_accept);
    start = 1'b1; a = x; b = y; cin = ci;
    if (expect_accept) begin
      q.push_back(model(x, y, ci));
      n_start++;
    end
    @(negedge clk);
    start = 1'b0;
    a = $urandom(); b = $urandom(); cin = 1'($urandom());
  endtask

  // Returns cycles since the accepting edge (1 = first negedge after it).
  task automatic wait_done(input int already, output int lat);
    lat = already;
    while (done !== 1'b1 && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    if (done !== 1'b1) chk("done_timeout", 32'(done), 32'd1);
  endtask

  initial begin
    int lat;
    int d0;
    rst_n = 1'b0; start = 1'b0; a = '0; b = '0; cin = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_sum", 32'(sum), 32'd0);
    chk("rst_cout", 32'(cout), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // 0x5A + 0x3C: latency and busy/done shape
    start_op(8'h5A, 8'h3C, 1'b0, 1'b1);
    chk("busy_first", 32'(busy), 32'd1);
    chk("done_first", 32'(done), 32'd0);
    wait_done(1, lat);
    chk("latency", 32'(lat), 32'(W + 1));
    chk("busy_at_done", 32'(busy), 32'd0);
    @(negedge clk);
    chk("done_one_cycle", 32'(done), 32'd0);
    chk("sum_held_idle", 32'(sum), 32'h96);

    start_op(8'hFF, 8'h01, 1'b0, 1'b1);
    wait_done(1, lat);
    @(negedge clk);
    start_op(8'h00, 8'h00, 1'b1, 1'b1);
    wait_done(1, lat);
    @(negedge clk);

    // start during RUN must be ignored
    d0 = n_done;
    start_op(8'h11, 8'h22, 1'b0, 1'b1);
    repeat (2) @(negedge clk);
    start_op(8'hFF, 8'hFF, 1'b1, 1'b0);
    wait_done(4, lat);
    chk("ignored_latency", 32'(lat), 32'(W + 1));
    repeat (12) @(negedge clk);
    chk("single_done", 32'(n_done - d0), 32'd1);

    // back-to-back: accept in DONE, prior result still visible after accept
    start_op(8'h12, 8'h34, 1'b0, 1'b1);
    wait_done(1, lat);
    start_op(8'h80, 8'h80, 1'b0, 1'b1);
    chk("held_after_accept", 32'(sum), 32'h46);
    chk("busy_b2b", 32'(busy), 32'd1);
    wait_done(1, lat);
    chk("b2b_latency", 32'(lat), 32'(W + 1));
    @(negedge clk);

    // reset mid-RUN discards the operation
    d0 = n_done;
    start_op(8'h11, 8'h22, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_done", 32'(done), 32'd0);
    chk("midrst_sum", 32'(sum), 32'd0);
    chk("midrst_cout", 32'(cout), 32'd0);
    rst_n = 1'b1;
    repeat (12) @(negedge clk);
    chk("midrst_no_done", 32'(n_done - d0), 32'd0);
    start_op(8'hC3, 8'h5E, 1'b1, 1'b1);
    wait_done(1, lat);
    @(negedge clk);

    // random sweep, mostly back-to-back
    for (int i = 0; i < 1000; i++) begin
      start_op(W'($urandom()), W'($urandom()), 1'($urandom()), 1'b1);
      wait_done(1, lat);
      if ($urandom_range(0, 3) == 0) @(negedge clk);
    end
    repeat (3) @(negedge clk);
    chk("done_vs_start", 32'(n_done), 32'(n_start));
    chk("queue_empty", 32'(q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
